// File: rtl/boot_pkg.sv
// Shared types and default constants for the boot loader.
// Imported by the FSM/counter block and its testbench.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_HDR,
    ST_LOAD,
    ST_ERR
  } boot_state_t;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RESET_HOLD = 4;
  localparam int DEF_TIMEOUT    = 1048576;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on a registered previous sample.
// The previous sample resets to 0, so a level high at reset release is an edge.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/boot_load_controller.sv
// Loads a length-prefixed word stream into instruction memory
// and holds the CPU in reset while loading.
module boot_load_controller
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RESET_HOLD = DEF_RESET_HOLD,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  boot_req,
  input  logic                  word_ready,
  input  logic [DATA_WIDTH-1:0] word_data,
  output logic                  imem_wEn,
  output logic [ADDR_WIDTH-1:0] imem_writeAddr,
  output logic [DATA_WIDTH-1:0] imem_dataIn,
  output logic                  cpu_reset,
  output logic                  loading,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1);

  logic w_word_rise;
  logic w_boot_rise;

  edge_detect u_word_ed (
    .clock   (clock),
    .reset   (reset),
    .i_level (word_ready),
    .o_rise  (w_word_rise)
  );

  edge_detect u_boot_ed (
    .clock   (clock),
    .reset   (reset),
    .i_level (boot_req),
    .o_rise  (w_boot_rise)
  );

  boot_state_t           r_state;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [IDLE_W-1:0]     r_idle;
  logic [ADDR_WIDTH:0]   r_length;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cpu_reset;
  logic                  r_loading;
  logic                  r_done;
  logic                  r_error;

  logic [ADDR_WIDTH:0] w_hdr_len;
  logic [ADDR_WIDTH:0] w_count_nx;
  logic                w_hdr_bad;
  logic                w_idle_exp;

  assign w_hdr_len  = word_data[ADDR_WIDTH:0];
  assign w_count_nx = r_count + CNT_ONE;
  assign w_hdr_bad  = (w_hdr_len == '0) || (w_hdr_len > MAX_LEN);
  assign w_idle_exp = (r_idle == IDLE_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_idle      <= '0;
      r_length    <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_loading   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state     <= ST_RUN;
            r_cpu_reset <= 1'b0;
            r_hold_cnt  <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (w_boot_rise) begin
            r_state     <= ST_HDR;
            r_cpu_reset <= 1'b1;
            r_loading   <= 1'b1;
            r_idle      <= '0;
          end
        end
        ST_HDR: begin
          if (w_word_rise) begin
            r_idle <= '0;
            if (w_hdr_bad) begin
              r_state   <= ST_ERR;
              r_loading <= 1'b0;
              r_error   <= 1'b1;
            end else begin
              r_state  <= ST_LOAD;
              r_length <= w_hdr_len;
              r_count  <= '0;
              r_addr   <= '0;
            end
          end else if (w_idle_exp) begin
            r_state   <= ST_ERR;
            r_loading <= 1'b0;
            r_error   <= 1'b1;
          end else begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        ST_LOAD: begin
          // final write is on the bus this cycle; leave LOAD one cycle later
          if (r_done) begin
            r_state    <= ST_HOLD;
            r_loading  <= 1'b0;
            r_hold_cnt <= '0;
          end else if (w_word_rise) begin
            r_idle  <= '0;
            r_wen   <= 1'b1;
            r_waddr <= r_addr;
            r_wdata <= word_data;
            r_addr  <= r_addr + ADR_ONE;
            r_count <= w_count_nx;
            r_done  <= (w_count_nx == r_length);
          end else if (w_idle_exp) begin
            r_state   <= ST_ERR;
            r_loading <= 1'b0;
            r_error   <= 1'b1;
          end else begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        ST_ERR: begin
          if (w_boot_rise) begin
            r_state   <= ST_HDR;
            r_error   <= 1'b0;
            r_loading <= 1'b1;
            r_idle    <= '0;
          end
        end
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  assign imem_wEn       = r_wen;
  assign imem_writeAddr = r_waddr;
  assign imem_dataIn    = r_wdata;
  assign cpu_reset      = r_cpu_reset;
  assign loading        = r_loading;
  assign load_done      = r_done;
  assign load_error     = r_error;
  assign word_count     = r_count;

endmodule

// File: doc/boot_load_controller.md
# boot_load_controller

Sequences the instruction-memory write port during program loading and gates the processor's reset. It receives words from the serial word receiver and writes them into consecutive instruction-memory addresses. The first word is a length header. The block holds the CPU in reset while loading, then releases it after a fixed hold interval. It sits between the word receiver, the ROM write port and the processor's `reset` input inside the top-level wrapper.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: instruction-memory address width.
- `DATA_WIDTH`, 32: word width.
- `RESET_HOLD`, 4: cycles the CPU is kept in reset after load or reset release (≥1).
- `TIMEOUT`, 1048576: maximum idle cycles between words in HDR/LOAD before an error.

Ports:
- `clock`  in  1: the only clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `boot_req`  in  1: level; a rising edge requests a new load.
- `word_ready`  in  1: receiver ready level; its rising edge marks one new word.
- `word_data`  in  DATA_WIDTH: received word; sampled on the `word_ready` rising edge.
- `imem_wEn`  out  1: ROM write enable.
- `imem_writeAddr`  out  ADDR_WIDTH: ROM write address.
- `imem_dataIn`  out  DATA_WIDTH: ROM write data.
- `cpu_reset`  out  1: drives the processor's `reset`.
- `loading`  out  1: high in HDR and LOAD.
- `load_done`  out  1: one-cycle pulse when the last word is written.
- `load_error`  out  1: high in ERR.
- `word_count`  out  ADDR_WIDTH+1: payload words written in the current load.

## Operation
- FSM states: HOLD, RUN, HDR, LOAD, ERR. The reset state is HOLD.
- HOLD: `cpu_reset`=1; a counter runs 0..RESET_HOLD-1, then the FSM goes to RUN. `boot_req` and words are ignored.
- RUN: `cpu_reset`=0. A `boot_req` rising edge moves the FSM to HDR. Words arriving in RUN are discarded.
- HDR: `cpu_reset`=1. The first word sets `length` = `word_data[ADDR_WIDTH:0]`.
  - `length`==0 or `length` > 2^ADDR_WIDTH → ERR.
  - Otherwise → LOAD, with the address and `word_count` cleared to 0.
- LOAD: each word is written at the current address; the address and `word_count` then increment. When `word_count` reaches `length`: pulse `load_done` and go to HOLD.
- Timeout: in HDR and LOAD, an idle counter clears on each word. When it reaches TIMEOUT → ERR.
- ERR: `cpu_reset`=1 and `load_error`=1. A `boot_req` rising edge goes to HDR and clears `load_error`.
- `boot_req` edges in HDR or LOAD are ignored; the current load continues.
- Address arithmetic is unsigned ADDR_WIDTH bits. The address never wraps, because `length` ≤ 2^ADDR_WIDTH ends the load first.
- Edge detection uses registered previous values of `word_ready` and `boot_req`. Their values at reset are 0, so a level already high when reset releases counts as an edge.

## Timing
- Reset values: `cpu_reset`=1, `imem_wEn`=0, `imem_writeAddr`=0, `imem_dataIn`=0, `loading`=0, `load_done`=0, `load_error`=0, `word_count`=0, state=HOLD.
- Edge detection: the rising edge is seen in cycle N, when `word_ready` is 1 and the registered previous value is 0.
- Write latency: `imem_wEn`, `imem_writeAddr` and `imem_dataIn` are registered and asserted in cycle N+1 for exactly one cycle.
- `load_done` is asserted in the same cycle as the final `imem_wEn`; the state is HOLD from N+2.
- `cpu_reset` falls exactly RESET_HOLD cycles after HOLD is entered.
- A `boot_req` edge in RUN raises `cpu_reset` the following cycle.
- Reset mid-load: all outputs return to reset values at once; any pending write is dropped. ROM contents are partially overwritten and not restored.
- The header word is never written to ROM.

## Structure
- Shared package `boot_pkg`: state encoding (HOLD, RUN, HDR, LOAD, ERR) and default parameter constants.
- One sub-module, `edge_detect`: registered rising-edge detector with asynchronous active-high reset. It is instantiated for `word_ready` and `boot_req`.
- Everything else lives in a single FSM/counter module.

## Test plan
- Reset release with no activity → `cpu_reset` high for 4 cycles, then 0; all other outputs at reset values.
- RUN, `boot_req` edge, header 3, words 0xA, 0xB, 0xC → writes (0,0xA), (1,0xB), (2,0xC), one `imem_wEn` each, one cycle after each edge. `load_done` coincides with the third write. `cpu_reset` falls 4 cycles later.
- Header 0, and separately header 4097 → ERR, `load_error`=1, no writes. A later `boot_req` plus a valid load succeeds and clears `load_error`.
- HDR with no words for TIMEOUT cycles (TIMEOUT=16 in the bench) → ERR. LOAD stalled after 1 of 3 words → ERR with `word_count`=1.
- `boot_req` toggled during LOAD → ignored, load completes normally. `word_ready` edges in RUN → no writes; `word_ready` held high for many cycles → exactly one write.
- Assert `reset` after 2 of 5 words → immediate reset values and state HOLD. After 4 cycles `cpu_reset`=0, with no further writes.
